// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU write-back path.
// Holds the bank-select encoding and the D operand field positions; the
// operand decoder uses the same definitions so both ends agree.
package alu_writeback_pkg;

    // Destination bank, taken from the top two bits of the D operand.
    typedef enum logic [1:0] {
        WB_BANK_A    = 2'b00,
        WB_BANK_B    = 2'b01,
        WB_BANK_IO   = 2'b10,
        WB_BANK_NONE = 2'b11
    } wb_bank_e;

    // D operand field positions.
    localparam int WB_BANK_HI = 11;
    localparam int WB_BANK_LO = 10;
    localparam int WB_ADDR_HI = 9;
    localparam int WB_ADDR_LO = 0;

endpackage

// File: rtl/wb_io_fifo.sv
// Single output-port FIFO for the write-back I/O bank.
// A circular buffer with read/write pointers and an occupancy count. Pushes
// to a full FIFO are dropped and raise a sticky overflow flag, unless a pop
// frees a slot in the same cycle.
// Ports:
//   clock, reset       - clock, asynchronous active-high reset
//   push, push_data    - write request and data
//   pop                - consumer ready; ignored while empty
//   valid, head        - FIFO non-empty, oldest entry (0 when empty)
//   overflow           - sticky drop flag
//   overflow_clear     - synchronous clear of overflow (a same-cycle set wins)
module wb_io_fifo
    import alu_writeback_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [WORD_WIDTH-1:0] head,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign valid  = (r_count != '0);
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a push to a full FIFO lands.
    assign w_push = push && (!w_full || w_pop);
    assign w_drop = push && w_full && !w_pop;

    // Gating keeps io_data at 0 whenever the port is empty, including
    // straight after reset when the storage holds stale words.
    assign head     = valid ? r_mem[r_rd_ptr] : '0;
    assign overflow = r_overflow;

    // NOTE: the storage array has no reset; its contents are only visible
    // through head, which is gated by valid, so resetting it buys nothing.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointers are power-of-two wide, so they wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Write-back decoder at the consumer end of the ALU result interface.
// Decodes the D operand into A memory, B memory, an I/O port FIFO or
// discard, and issues a one-cycle registered write. I/O writes never stall
// the datapath; a full port FIFO drops the word and flags overflow.
// Ports:
//   clock, reset                 - clock, asynchronous active-high reset
//   in_valid, R_in, op_in, D_in  - ALU result, opcode and destination
//   A_wren/A_addr/A_data         - A memory write port
//   B_wren/B_addr/B_data         - B memory write port
//   io_valid/io_ready/io_data    - per-port output handshake, port p at [p*W +: W]
//   io_overflow/_clear           - sticky per-port drop flags and their clears
//   last_op                      - opcode of the last valid instruction
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int WORD_WIDTH      = 36,
    parameter int OPCODE_WIDTH    = 4,
    parameter int D_OPERAND_WIDTH = 12,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int IO_PORT_COUNT   = 4,
    parameter int IO_FIFO_DEPTH   = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [WORD_WIDTH-1:0]                 R_in,
    input  logic [OPCODE_WIDTH-1:0]               op_in,
    input  logic [D_OPERAND_WIDTH-1:0]            D_in,
    output logic                                  A_wren,
    output logic [MEM_ADDR_WIDTH-1:0]             A_addr,
    output logic [WORD_WIDTH-1:0]                 A_data,
    output logic                                  B_wren,
    output logic [MEM_ADDR_WIDTH-1:0]             B_addr,
    output logic [WORD_WIDTH-1:0]                 B_data,
    output logic [IO_PORT_COUNT-1:0]              io_valid,
    input  logic [IO_PORT_COUNT-1:0]              io_ready,
    output logic [IO_PORT_COUNT*WORD_WIDTH-1:0]   io_data,
    output logic [IO_PORT_COUNT-1:0]              io_overflow,
    input  logic [IO_PORT_COUNT-1:0]              io_overflow_clear,
    output logic [OPCODE_WIDTH-1:0]               last_op
);

    // At least one select bit so the slice stays legal with a single port.
    localparam int PORT_SEL_W = (IO_PORT_COUNT > 1) ? $clog2(IO_PORT_COUNT) : 1;

    wb_bank_e                  w_bank;
    logic [MEM_ADDR_WIDTH-1:0] w_addr;
    logic [PORT_SEL_W-1:0]     w_port_sel;
    logic                      w_a_wr;
    logic                      w_b_wr;
    logic                      w_io_wr;
    logic [IO_PORT_COUNT-1:0]  w_io_push;

    assign w_bank     = wb_bank_e'(D_in[WB_BANK_HI:WB_BANK_LO]);
    assign w_addr     = D_in[WB_ADDR_HI:WB_ADDR_LO];
    assign w_port_sel = D_in[PORT_SEL_W-1:0];

    assign w_a_wr  = in_valid && (w_bank == WB_BANK_A);
    assign w_b_wr  = in_valid && (w_bank == WB_BANK_B);
    assign w_io_wr = in_valid && (w_bank == WB_BANK_IO);

    // A/B write ports: address and data only load on a write so they hold
    // their last values while wren is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            A_wren  <= 1'b0;
            A_addr  <= '0;
            A_data  <= '0;
            B_wren  <= 1'b0;
            B_addr  <= '0;
            B_data  <= '0;
            last_op <= '0;
        end else begin
            A_wren <= w_a_wr;
            B_wren <= w_b_wr;
            if (w_a_wr) begin
                A_addr <= w_addr;
                A_data <= R_in;
            end
            if (w_b_wr) begin
                B_addr <= w_addr;
                B_data <= R_in;
            end
            if (in_valid) begin
                last_op <= op_in;
            end
        end
    end

    // One FIFO per output port; the upper address bits of an I/O
    // destination are ignored.
    for (genvar p = 0; p < IO_PORT_COUNT; p++) begin : g_port
        assign w_io_push[p] = w_io_wr &&
                              ((IO_PORT_COUNT == 1) || (w_port_sel == PORT_SEL_W'(p)));

        wb_io_fifo #(
            .WORD_WIDTH (WORD_WIDTH),
            .DEPTH      (IO_FIFO_DEPTH)
        ) u_fifo (
            .clock          (clock),
            .reset          (reset),
            .push           (w_io_push[p]),
            .push_data      (R_in),
            .pop            (io_ready[p]),
            .valid          (io_valid[p]),
            .head           (io_data[p*WORD_WIDTH +: WORD_WIDTH]),
            .overflow       (io_overflow[p]),
            .overflow_clear (io_overflow_clear[p])
        );
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Write-back decoder at the consumer end of the ALU result interface. It takes the registered ALU result `R`, `op_out` and `D_out`, decodes the D operand into a destination, and issues a one-cycle write to the A or B data memory. I/O destinations are pushed into per-port output FIFOs, which drain to external consumers over a valid/ready handshake. The datapath never stalls, so I/O back-pressure never propagates upstream: a full FIFO drops the write and flags it.

## Interface
Parameters:
- `WORD_WIDTH`, 36: result and data width.
- `OPCODE_WIDTH`, 4: width of `op_in`; carried for debug/trace only.
- `D_OPERAND_WIDTH`, 12: width of the destination operand. Bits [11:10] select the bank; bits [9:0] are the address.
- `MEM_ADDR_WIDTH`, 10: A/B memory address width; must equal `D_OPERAND_WIDTH`-2.
- `IO_PORT_COUNT`, 4: number of output ports; power of two, at most 2^`MEM_ADDR_WIDTH`.
- `IO_FIFO_DEPTH`, 4: entries per port FIFO; power of two, at least 2.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `in_valid`, in, 1: the result on the inputs is a real instruction. Low means annulled or bubble.
- `R_in`, in, `WORD_WIDTH`: ALU result.
- `op_in`, in, `OPCODE_WIDTH`: ALU `op_out`.
- `D_in`, in, `D_OPERAND_WIDTH`: ALU `D_out`.
- `A_wren`, out, 1: A memory write enable.
- `A_addr`, out, `MEM_ADDR_WIDTH`: A memory write address.
- `A_data`, out, `WORD_WIDTH`: A memory write data.
- `B_wren`, out, 1: B memory write enable.
- `B_addr`, out, `MEM_ADDR_WIDTH`: B memory write address.
- `B_data`, out, `WORD_WIDTH`: B memory write data.
- `io_valid`, out, `IO_PORT_COUNT`: per-port FIFO non-empty.
- `io_ready`, in, `IO_PORT_COUNT`: per-port consumer ready.
- `io_data`, out, `IO_PORT_COUNT`*`WORD_WIDTH`: head of each FIFO. Port p occupies bits [p*W +: W].
- `io_overflow`, out, `IO_PORT_COUNT`: sticky per-port drop flag.
- `io_overflow_clear`, in, `IO_PORT_COUNT`: per-port synchronous clear of `io_overflow`.
- `last_op`, out, `OPCODE_WIDTH`: opcode of the last valid instruction, registered; for trace.

## Operation
- Bank decode on D[11:10]:
  - 00: A memory.
  - 01: B memory.
  - 10: I/O port D[log2(`IO_PORT_COUNT`)-1:0]; the remaining address bits are ignored.
  - 11: discard. Used by compare and branch-only instructions.
- `in_valid`=0: no write of any kind, and `last_op` holds.
- A/B write: `wren`, `addr` and `data` are registered together and asserted for exactly one cycle. Addr and data hold their last values while wren=0.
- I/O push: each port has a circular FIFO with read/write pointers and a count register.
- Push to a full FIFO:
  - the entry is dropped;
  - `io_overflow[p]` is set;
  - the FIFO contents are unchanged.
- Pop happens when `io_valid[p]` && `io_ready[p]`. `io_ready` with the FIFO empty is ignored.
- Simultaneous push and pop on a full FIFO: both take effect, the count is unchanged, and no overflow is raised.
- Simultaneous push and pop on an empty FIFO is impossible, because `io_valid` is 0. The push lands normally.
- Set and clear of `io_overflow` in the same cycle: set wins.
- Pointers wrap modulo `IO_FIFO_DEPTH`.

## Timing
- Latency input to A/B write: 1 cycle. An input sampled at edge N gives `wren` high for the cycle after edge N.
- Latency input to `io_valid`: 1 cycle when the FIFO was empty. `io_data` is valid whenever `io_valid` is high.
- `io_valid` must not depend combinationally on `io_ready`. `io_data` and `io_valid` come from registers and the FIFO read mux only.
- Throughput: one result per cycle sustained. Each port FIFO sustains one push and one pop per cycle.
- Reset values:
  - `A_wren`, `B_wren`: 0.
  - `A_addr`, `A_data`, `B_addr`, `B_data`: 0.
  - `io_valid`: 0. `io_data`: 0.
  - `io_overflow`: 0.
  - `last_op`: 0.
  - All FIFO pointers and counts: 0.
- Reset mid-operation: FIFO contents are discarded. An in-flight A/B write is cancelled, and wren is forced to 0 immediately (asynchronous).

## Structure
- Shared package: bank-select constants (`WB_BANK_A`=2'b00, `WB_BANK_B`=2'b01, `WB_BANK_IO`=2'b10, `WB_BANK_NONE`=2'b11), and the D-field bit positions, shared with the operand decoder.
- Sub-module `wb_io_fifo`, instantiated once per port. It holds the storage, pointers, count and overflow logic, and exposes `push`, `push_data`, `pop`, `valid`, `head`, `overflow` and `overflow_clear`.
- The top level contains the decode, the A/B output registers, the generate loop and `last_op`.

## Test plan
- Valid result R=36'h123456789 with D=12'h005 → A_wren=1, A_addr=5, A_data=36'h123456789 one cycle later. B_wren stays 0.
- Results with D=12'h7FF (bank 01), then D=12'hC00 (discard) → one B write to address 10'h3FF. The discard produces no A, B or I/O activity. With `in_valid`=0 on the same D, there is no write.
- Push five words 1..5 to port 2 with `io_ready[2]`=0 → words 1..4 are held and `io_overflow[2]`=1. After `io_ready[2]` rises, the port pops 1,2,3,4 on consecutive cycles, then `io_valid[2]`=0.
- Port 0 full with `io_ready[0]`=1 and a push of value 9 in the same cycle → count stays 4 and there is no overflow. 9 emerges after the three older entries.
- Assert `reset` while port 1 holds 3 entries and a B write is in flight → `io_valid`=0, `B_wren`=0 and `io_overflow`=0 immediately. After deassertion, the first push to port 1 appears one cycle later as the only entry.
